in_service_ctrl: RTL

Parametrised, clocked in-service register (ISR) controller for the PIC core, sized for `NUM_IRQ` request lines. It latches acknowledged interrupts and executes OCW2-style end-of-interrupt (EOI) and rotation commands. It owns the rotation pointer and resolves the highest-priority level in service, honouring special mask mode. The priority-resolver and control-logic blocks consume its outputs.

---
 rtl/in_service_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/in_service_ctrl.sv
// in_service_ctrl: in-service register, EOI/rotation commands and in-service priority resolution
module in_service_ctrl #(
  parameter int NUM_IRQ = 8,
  localparam int PTR_W = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ack_valid,
  input  logic [NUM_IRQ-1:0] ack_vector,
  input  logic               auto_eoi,
  input  logic               eoi_valid,
  input  logic [2:0]         eoi_cmd,
  input  logic [PTR_W-1:0]   eoi_level,
  input  logic               special_mask_mode,
  input  logic [NUM_IRQ-1:0] interrupt_mask,
  output logic [NUM_IRQ-1:0] in_service_register,
  output logic [NUM_IRQ-1:0] highest_level_in_service,
  output logic [PTR_W-1:0]   priority_rotate,
  output logic               rotate_in_aeoi,
  output logic               eoi_error
);
  function automatic logic [PTR_W-1:0] low_idx(input logic [NUM_IRQ-1:0] v);
    low_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (v[i]) low_idx = PTR_W'(i);
  endfunction

  logic [NUM_IRQ-1:0]   eff, rot, pick, hl;
  logic [PTR_W-1:0]     sh;
  logic [2*NUM_IRQ-1:0] dbl_r, dbl_l;
  logic [NUM_IRQ-1:0]   isr_n;
  logic [PTR_W-1:0]     ptr_n;
  logic                 raeoi_n, err_n;

  // Rotate so the highest-priority level lands at bit 0, isolate the lowest set bit, rotate back
  always_comb begin
    eff   = in_service_register & ~(special_mask_mode ? interrupt_mask : '0);
    sh    = priority_rotate + PTR_W'(1);
    dbl_r = {eff, eff} >> sh;
    rot   = dbl_r[NUM_IRQ-1:0];
    pick  = rot & (~rot + NUM_IRQ'(1));
    dbl_l = {pick, pick} << sh;
    hl    = dbl_l[2*NUM_IRQ-1:NUM_IRQ];
  end

  // Next state: EOI/mode command acts on the current ISR first, then the ack is merged and its AEOI rotate wins
  always_comb begin
    isr_n   = in_service_register;
    ptr_n   = priority_rotate;
    raeoi_n = rotate_in_aeoi;
    err_n   = 1'b0;
    if (eoi_valid) begin
      case (eoi_cmd)
        3'b001, 3'b101: begin
          if (hl == '0) err_n = 1'b1;
          else begin
            isr_n = isr_n & ~hl;
            if (eoi_cmd[2]) ptr_n = low_idx(hl);
          end
        end
        3'b011, 3'b111: begin
          err_n = ~in_service_register[eoi_level];
          isr_n[eoi_level] = 1'b0;
          if (eoi_cmd[2]) ptr_n = eoi_level;
        end
        3'b110: ptr_n = eoi_level;
        3'b100: raeoi_n = 1'b1;
        3'b000: raeoi_n = 1'b0;
        default: ;
      endcase
    end
    if (ack_valid && ack_vector != '0) begin
      if (!auto_eoi) isr_n = isr_n | ack_vector;
      else if (rotate_in_aeoi) ptr_n = low_idx(ack_vector);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_service_register      <= '0;
      highest_level_in_service <= '0;
      priority_rotate          <= PTR_W'(NUM_IRQ - 1);
      rotate_in_aeoi           <= 1'b0;
      eoi_error                <= 1'b0;
    end else begin
      in_service_register      <= isr_n;
      highest_level_in_service <= hl;
      priority_rotate          <= ptr_n;
      rotate_in_aeoi           <= raeoi_n;
      eoi_error                <= err_n;
    end
  end
endmodule
